// File: rtl/screen_design.sv
// ---------------------------------------------------------------------------
// screen_design: VGA 640x480@60 Hz timing generator with a built-in
// eight-bar 1-bit-RGB colour test pattern.
//
// Ports:
//   clk     in   system clock, all logic on its rising edge
//   rst     in   synchronous active-low reset (rst=0 at an edge clears counters)
//   h_sync  out  horizontal sync, active low
//   v_sync  out  vertical sync, active low
//   r_out   out  red pixel bit
//   g_out   out  green pixel bit
//   b_out   out  blue pixel bit
//   temp    out  pixel-enable strobe, one clk wide (debug / scope trigger)
//
// No FSM here: the block is a clock divider feeding two cascaded counters,
// with all outputs decoded combinationally from the registered counters.
// H_TOTAL and V_TOTAL must both fit the 10-bit counters (<= 1024).
// ---------------------------------------------------------------------------
module screen_design #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic clk,
    input  logic rst,
    output logic h_sync,
    output logic v_sync,
    output logic r_out,
    output logic g_out,
    output logic b_out,
    output logic temp
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_W   = H_VISIBLE / 8;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;

    logic       tick;
    logic       video_on;
    logic [2:0] bar_idx;

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_q <= '0;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
        end
    end

    // ---------------- next-state logic ----------------
    assign tick = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        if (tick) begin
            div_cnt_d = '0;
            if (h_cnt_q == H_LAST) begin
                // Line wrap is the only event that advances the line counter,
                // so a frame wrap takes both counters to 0 on the same edge.
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- pattern decode ----------------
    assign video_on = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);

    // Bar index by comparator chain: the thresholds are increasing, so the
    // last threshold that h_cnt has reached names the bar.
    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h_cnt_q >= 10'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
    end

    // Outputs fall back to their idle values while rst is low, without
    // waiting for the counters to clear at the next edge.
    always_comb begin
        h_sync = 1'b1;
        v_sync = 1'b1;
        r_out  = 1'b0;
        g_out  = 1'b0;
        b_out  = 1'b0;
        temp   = 1'b0;
        if (rst) begin
            h_sync = !((h_cnt_q >= HS_START) && (h_cnt_q <= HS_END));
            v_sync = !((v_cnt_q >= VS_START) && (v_cnt_q <= VS_END));
            temp   = tick;
            if (video_on) begin
                // Colour is 7-k, which for a 3-bit k is its bitwise inverse.
                {r_out, g_out, b_out} = ~bar_idx;
            end
        end
    end

endmodule

// File: tb/tb_screen_design.sv
// ---------------------------------------------------------------------------
// tb_screen_design: directed bench for screen_design.
//   dut_a : default 640x480 timing, CLK_DIV=4 (line timing, colour bars,
//           mid-line reset).
//   dut_b : same horizontal timing, 8-line frame (V 4/1/2/1), CLK_DIV=2, so a
//           whole frame, the vertical sync window, vertical blanking and the
//           frame wrap all fit in a short run.
// Observed vector layout: {h_sync, v_sync, r, g, b, temp}.
// Expected vectors are hand-computed from k = edges since reset release:
//   A: h = (k/4) mod 800, line = k/3200, temp = (k mod 4 == 3)
//   B: h = (k/2) mod 800, line = (k/1600) mod 8, temp = (k mod 2 == 1)
// ---------------------------------------------------------------------------
module tb_screen_design;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;

    always #5 clk = ~clk;

    logic h_sync_a, v_sync_a, r_a, g_a, b_a, temp_a;
    logic h_sync_b, v_sync_b, r_b, g_b, b_b, temp_b;

    screen_design dut_a (
        .clk    (clk),
        .rst    (rst_a),
        .h_sync (h_sync_a),
        .v_sync (v_sync_a),
        .r_out  (r_a),
        .g_out  (g_a),
        .b_out  (b_a),
        .temp   (temp_a)
    );

    screen_design #(
        .CLK_DIV   (2),
        .V_VISIBLE (4),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (1)
    ) dut_b (
        .clk    (clk),
        .rst    (rst_b),
        .h_sync (h_sync_b),
        .v_sync (v_sync_b),
        .r_out  (r_b),
        .g_out  (g_b),
        .b_out  (b_b),
        .temp   (temp_b)
    );

    // ---------------- scoreboard counters ----------------
    int pass_cnt  = 0;
    int total_cnt = 0;
    int ka = 0;
    int kb = 0;

    function automatic logic [5:0] obs_a();
        return {h_sync_a, v_sync_a, r_a, g_a, b_a, temp_a};
    endfunction

    function automatic logic [5:0] obs_b();
        return {h_sync_b, v_sync_b, r_b, g_b, b_b, temp_b};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // ---------------- driver tasks ----------------
    // One edge, then sample 1 ns later, away from the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        ka++;
        kb++;
    endtask

    task automatic chk_a(input string tag, input int k, input logic [5:0] exp);
        while (ka < k) step();
        check(tag, obs_a(), exp);
    endtask

    task automatic chk_b(input string tag, input int k, input logic [5:0] exp);
        while (kb < k) step();
        check(tag, obs_b(), exp);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        // Reset held for 100 ns: both instances idle.
        for (int i = 0; i < 10; i++) begin
            step();
            check("rst_hold_a", obs_a(), 6'b11_000_0);
            check("rst_hold_b", obs_b(), 6'b11_000_0);
        end

        // Release A; strobe on every 4th edge, pixel 0..3 all white.
        rst_a = 1'b1;
        ka = 0;
        #1;
        check("a_release_k0", obs_a(), 6'b11_111_0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("a_strobe", obs_a(), {5'b11_111, (k % 4 == 3)});
        end

        // Colour bars across line 0.
        chk_a("a_h79_white",    319,  6'b11_111_1);
        chk_a("a_h80_yellow",   320,  6'b11_110_0);
        chk_a("a_h160_magenta", 640,  6'b11_101_0);
        chk_a("a_h240_red",     960,  6'b11_100_0);
        chk_a("a_h320_cyan",    1280, 6'b11_011_0);
        chk_a("a_h400_green",   1600, 6'b11_010_0);
        chk_a("a_h480_blue",    1920, 6'b11_001_0);
        chk_a("a_h559_blue",    2239, 6'b11_001_1);
        chk_a("a_h560_black",   2240, 6'b11_000_0);
        chk_a("a_h639_black",   2559, 6'b11_000_1);
        chk_a("a_h640_blank",   2560, 6'b11_000_0);

        // Horizontal sync window 656..751, line period 3200 clk.
        chk_a("a_l0_h655",      2623, 6'b11_000_1);
        chk_a("a_l0_hs_fall",   2624, 6'b01_000_0);
        chk_a("a_l0_h751",      3007, 6'b01_000_1);
        chk_a("a_l0_hs_rise",   3008, 6'b11_000_0);
        chk_a("a_l0_h799",      3199, 6'b11_000_1);
        chk_a("a_l1_h0",        3200, 6'b11_111_0);
        chk_a("a_l1_h655",      5823, 6'b11_000_1);
        chk_a("a_l1_hs_fall",   5824, 6'b01_000_0);
        chk_a("a_l1_h751",      6207, 6'b01_000_1);
        chk_a("a_l1_hs_rise",   6208, 6'b11_000_0);
        chk_a("a_l2_h300_red",  7600, 6'b11_100_0);

        // Mid-line reset on A: outputs idle immediately, counters cleared.
        rst_a = 1'b0;
        #1;
        check("a_midrst_comb", obs_a(), 6'b11_000_0);
        step();
        check("a_midrst_edge", obs_a(), 6'b11_000_0);
        rst_a = 1'b1;
        ka = 0;
        #1;
        check("a_restart_k0", obs_a(), 6'b11_111_0);
        chk_a("a_restart_tick",   3,    6'b11_111_1);
        chk_a("a_restart_h80",    320,  6'b11_110_0);
        chk_a("a_restart_h655",   2623, 6'b11_000_1);
        chk_a("a_restart_hsfall", 2624, 6'b01_000_0);

        // B held in reset so far; release it and walk one whole frame.
        check("b_still_rst", obs_b(), 6'b11_000_0);
        rst_b = 1'b1;
        kb = 0;
        #1;
        check("b_release_k0", obs_b(), 6'b11_111_0);
        chk_b("b_k1_tick",       1,     6'b11_111_1);
        chk_b("b_l3_h0",         4800,  6'b11_111_0);
        chk_b("b_l3_h799",       6399,  6'b11_000_1);
        chk_b("b_l4_vblank",     6400,  6'b11_000_0);
        chk_b("b_l4_h799",       7999,  6'b11_000_1);
        chk_b("b_l5_vs_fall",    8000,  6'b10_000_0);
        chk_b("b_l5_hs_vs",      9312,  6'b00_000_0);
        chk_b("b_l6_h799",       11199, 6'b10_000_1);
        chk_b("b_l7_vs_rise",    11200, 6'b11_000_0);
        chk_b("b_l7_h799",       12799, 6'b11_000_1);
        chk_b("b_frame_wrap",    12800, 6'b11_111_0);
        chk_b("b_f1_l4_h0",      19200, 6'b11_000_0);
        chk_b("b_f1_l4_h300",    19800, 6'b11_000_0);

        // Mid-frame reset on B: vertical counter must restart too.
        rst_b = 1'b0;
        #1;
        check("b_midrst_comb", obs_b(), 6'b11_000_0);
        step();
        check("b_midrst_edge", obs_b(), 6'b11_000_0);
        rst_b = 1'b1;
        kb = 0;
        #1;
        check("b_restart_k0", obs_b(), 6'b11_111_0);
        chk_b("b_restart_tick",  1,    6'b11_111_1);
        chk_b("b_restart_vs",    8000, 6'b10_000_0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
